aes_key_schedule_iter: RTL and testbench

//  Iterative, multi-length AES key schedule (128/192/256) computing one 32-bit word per clock.

---
 rtl/aes_key_schedule_iter.sv | 251 +++++++++++++++++++++++++
 tb/tb_aes_key_schedule_iter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128/192/256 key expansion, one 32-bit word per clock, with random-access round-key read.
// Define KS_ZEROIZE_EN to add a zeroize input that wipes the stored schedule.
module aes_key_schedule_iter #(
  parameter int ENABLE_192 = 1,
  parameter int ENABLE_256 = 1,
  parameter int RD_REG     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         start,
`ifdef KS_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic         busy,
  output logic         done,
  output logic         keys_ready,
  output logic         key_err,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         rk_oob
);

  localparam int NW = (ENABLE_256 != 0) ? 60 : ((ENABLE_192 != 0) ? 52 : 44);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_EXPAND = 2'd2} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic key_len_ok(input logic [1:0] kl);
    logic ok;
    case (kl)
      2'b00:   ok = 1'b1;
      2'b01:   ok = (ENABLE_192 != 0);
      2'b10:   ok = (ENABLE_256 != 0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] pick_word(input logic [31:0] arr [NW], input logic [5:0] a);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < NW; k++) begin
      if (a == 6'(k)) r = arr[k];
    end
    return r;
  endfunction

  // Words hold FIPS byte r of the word in bits [8r+:8], so key words map straight from key_in.
  state_t        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [5:0]    i_q, i_d;
  logic [2:0]    j_q, j_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [31:0]   buf_q [NW];
  logic [31:0]   buf_d [NW];
  logic          busy_q, busy_d, done_q, done_d;
  logic          keys_ready_q, keys_ready_d, key_err_q, key_err_d;
  logic [5:0]    nk_s, wlast_s;
  logic [2:0]    nkm1_s;
  logic [3:0]    nr_s;
  logic [31:0]   w_prev_s, w_old_s, t_s, w_new_s;
  logic          rd_ok_s;
  logic [127:0]  rd_data_s;

  // Mode-dependent key-schedule constants.
  always_comb begin
    case (mode_q)
      2'b01:   begin nk_s = 6'd6; nkm1_s = 3'd5; nr_s = 4'd12; wlast_s = 6'd51; end
      2'b10:   begin nk_s = 6'd8; nkm1_s = 3'd7; nr_s = 4'd14; wlast_s = 6'd59; end
      default: begin nk_s = 6'd4; nkm1_s = 3'd3; nr_s = 4'd10; wlast_s = 6'd43; end
    endcase
  end

  // One expansion step: w[i] = w[i-Nk] ^ f(w[i-1]).
  always_comb begin
    w_prev_s = pick_word(buf_q, i_q - 6'd1);
    w_old_s  = pick_word(buf_q, i_q - nk_s);
    if (j_q == 3'd0) begin
      t_s = sub_word({w_prev_s[7:0], w_prev_s[31:8]}) ^ {24'h0, rcon_q};
    end else if ((nk_s == 6'd8) && (j_q == 3'd4)) begin
      t_s = sub_word(w_prev_s);
    end else begin
      t_s = w_prev_s;
    end
    w_new_s = w_old_s ^ t_s;
  end

  // Control FSM next state and buffer update.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    i_d          = i_q;
    j_d          = j_q;
    rcon_d       = rcon_q;
    buf_d        = buf_q;
    done_d       = 1'b0;
    key_err_d    = 1'b0;
    keys_ready_d = keys_ready_q;
    case (state_q)
      S_IDLE: begin
        if (start && key_len_ok(key_len)) begin
          state_d      = S_LOAD;
          mode_d       = key_len;
          keys_ready_d = 1'b0;
        end else if (start) begin
          key_err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        for (int k = 0; k < 8; k++) begin
          if (6'(k) < nk_s) buf_d[k] = key_in[32*k +: 32];
        end
        i_d     = nk_s;
        j_d     = 3'd0;
        rcon_d  = 8'h01;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        for (int k = 0; k < NW; k++) begin
          if (i_q == 6'(k)) buf_d[k] = w_new_s;
        end
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        else             rcon_d = rcon_q;
        j_d = (j_q == nkm1_s) ? 3'd0 : (j_q + 3'd1);
        i_d = i_q + 6'd1;
        if (i_q == wlast_s) begin
          state_d      = S_IDLE;
          done_d       = 1'b1;
          keys_ready_d = 1'b1;
        end else begin
          state_d = S_EXPAND;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef KS_ZEROIZE_EN
    if (zeroize) begin
      for (int k = 0; k < NW; k++) buf_d[k] = 32'h0;
      state_d      = S_IDLE;
      i_d          = 6'd0;
      j_d          = 3'd0;
      rcon_d       = 8'h00;
      done_d       = 1'b0;
      key_err_d    = 1'b0;
      keys_ready_d = 1'b0;
    end else begin
      state_d = state_d;
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  // State, schedule buffer and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'b00;
      i_q          <= 6'd0;
      j_q          <= 3'd0;
      rcon_q       <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      key_err_q    <= 1'b0;
      for (int k = 0; k < NW; k++) buf_q[k] <= 32'h0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      i_q          <= i_d;
      j_q          <= j_d;
      rcon_q       <= rcon_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_ready_q <= keys_ready_d;
      key_err_q    <= key_err_d;
      buf_q        <= buf_d;
    end
  end

  // Round-key read: transpose four column words into row-major order.
  always_comb begin
    logic [31:0] col_w;
    col_w     = 32'h0;
    rd_data_s = 128'h0;
    rd_ok_s   = keys_ready_q && (rk_idx <= nr_s);
    for (int c = 0; c < 4; c++) begin
      col_w = pick_word(buf_q, {rk_idx, 2'(c)});
      for (int r = 0; r < 4; r++) begin
        rd_data_s[32*r + 8*c +: 8] = rd_ok_s ? col_w[8*r +: 8] : 8'h00;
      end
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [127:0] rk_data_q;
      logic         rk_oob_q;
      // Registered read port.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rk_data_q <= 128'h0;
          rk_oob_q  <= 1'b1;
        end else begin
          rk_data_q <= rd_data_s;
          rk_oob_q  <= ~rd_ok_s;
        end
      end
      assign rk_data = rk_data_q;
      assign rk_oob  = rk_oob_q;
    end else begin : g_rd_comb
      assign rk_data = rd_data_s;
      assign rk_oob  = ~rd_ok_s;
    end
  endgenerate

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_ready = keys_ready_q;
  assign key_err    = key_err_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Directed bench for aes_key_schedule_iter: FIPS-197 vectors, error/bounds cases, interference and reset.
module tb_aes_key_schedule_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         start;
  logic [3:0]   rk_idx;
`ifdef KS_ZEROIZE_EN
  logic         zeroize;
`endif
  logic         busy, done, keys_ready, key_err, rk_oob;
  logic [127:0] rk_data;
  logic         busy2, done2, keys_ready2, key_err2, rk_oob2;
  logic [127:0] rk_data2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_key_schedule_iter #(.ENABLE_192(1), .ENABLE_256(1), .RD_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_len(key_len), .start(start),
`ifdef KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy), .done(done), .keys_ready(keys_ready), .key_err(key_err),
    .rk_idx(rk_idx), .rk_data(rk_data), .rk_oob(rk_oob)
  );

  // No AES-256, combinational read port.
  aes_key_schedule_iter #(.ENABLE_192(1), .ENABLE_256(0), .RD_REG(0)) u_dut_n256 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_len(key_len), .start(start),
`ifdef KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy2), .done(done2), .keys_ready(keys_ready2), .key_err(key_err2),
    .rk_idx(rk_idx), .rk_data(rk_data2), .rk_oob(rk_oob2)
  );

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fips_key(input logic [255:0] hex, input int nbytes);
    logic [255:0] k;
    k = 256'h0;
    for (int b = 0; b < nbytes; b++) k[8*b +: 8] = hex[8*(nbytes-1-b) +: 8];
    return k;
  endfunction

  function automatic logic [127:0] make_rk(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
    logic [127:0] d;
    logic [31:0]  w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    d = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) d[32*r + 8*c +: 8] = w[c][8*(3-r) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] d, input int c);
    return {d[8*c +: 8], d[32 + 8*c +: 8], d[64 + 8*c +: 8], d[96 + 8*c +: 8]};
  endfunction

  task automatic run_key(input logic [255:0] key, input logic [1:0] len, input bit interfere,
                         output int cycles);
    int cnt;
    @(negedge clk);
    key_in = key; key_len = len; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_value("busy_in_load", 128'(busy), 128'(1'b1));
    check_value("keys_ready_drop", 128'(keys_ready), 128'(1'b0));
    cnt = 0;
    while (cnt < 200) begin
      if (interfere && (cnt == 5 || cnt == 15)) begin
        start = 1'b1; key_len = 2'b01; key_in = ~key;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 20) check_value("oob_mid_expand", 128'(rk_oob), 128'(1'b1));
      if (done) break;
    end
    start = 1'b0;
    cycles = cnt;
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] d, output logic o,
                         output logic [127:0] d2, output logic o2);
    @(negedge clk);
    rk_idx = idx;
    #1;
    d2 = rk_data2; o2 = rk_oob2;
    @(posedge clk);
    @(negedge clk);
    d = rk_data; o = rk_oob;
  endtask

  logic [255:0] k128, k192, k256;
  logic [127:0] d, d2;
  logic         o, o2;
  int           cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = 256'h0; key_len = 2'b00; rk_idx = 4'd0;
`ifdef KS_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    k128 = fips_key(256'h2b7e151628aed2a6abf7158809cf4f3c, 16);
    k192 = fips_key(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 24);
    k256 = fips_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 32);
    repeat (3) @(negedge clk);
    check_value("rst_busy", 128'(busy), 128'(1'b0));
    check_value("rst_done", 128'(done), 128'(1'b0));
    check_value("rst_keys_ready", 128'(keys_ready), 128'(1'b0));
    check_value("rst_key_err", 128'(key_err), 128'(1'b0));
    check_value("rst_rk_data", rk_data, 128'h0);
    check_value("rst_rk_oob", 128'(rk_oob), 128'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128 with start pulses injected during expansion.
    run_key(k128, 2'b00, 1'b1, cyc);
    check_value("lat128", 128'(cyc), 128'(41));
    check_value("kr128", 128'(keys_ready), 128'(1'b1));
    read_rk(4'd0, d, o, d2, o2);
    check_value("rk128_0", d, make_rk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c));
    read_rk(4'd1, d, o, d2, o2);
    check_value("rk128_1", d, make_rk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
    check_value("rk128_1_oob", 128'(o), 128'(1'b0));
    check_value("rk128_1_comb", d2, make_rk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
    read_rk(4'd10, d, o, d2, o2);
    check_value("rk128_10", d, make_rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
    check_value("rk128_10_comb", d2, make_rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
    read_rk(4'd11, d, o, d2, o2);
    check_value("rk128_11_oob", 128'(o), 128'(1'b1));
    check_value("rk128_11_data", d, 128'h0);
    check_value("rk128_11_oob_comb", 128'(o2), 128'(1'b1));

    // Reserved key_len: error pulse, schedule untouched.
    @(negedge clk);
    key_len = 2'b11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_value("err11_pulse", 128'(key_err), 128'(1'b1));
    check_value("err11_busy", 128'(busy), 128'(1'b0));
    @(posedge clk);
    @(negedge clk);
    check_value("err11_pulse_end", 128'(key_err), 128'(1'b0));
    check_value("err11_keys_kept", 128'(keys_ready), 128'(1'b1));
    read_rk(4'd1, d, o, d2, o2);
    check_value("err11_rk1", d, make_rk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));

    // AES-192.
    run_key(k192, 2'b01, 1'b0, cyc);
    check_value("lat192", 128'(cyc), 128'(47));
    read_rk(4'd12, d, o, d2, o2);
    check_value("rk192_12_c3", 128'(get_col(d, 3)), 128'(32'h01002202));
    check_value("rk192_12_oob", 128'(o), 128'(1'b0));
    read_rk(4'd13, d, o, d2, o2);
    check_value("rk192_13_oob", 128'(o), 128'(1'b1));

    // AES-256; the no-256 instance must flag it.
    @(negedge clk);
    key_in = k256; key_len = 2'b10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_value("n256_key_err", 128'(key_err2), 128'(1'b1));
    check_value("n256_busy", 128'(busy2), 128'(1'b0));
    check_value("b256_busy", 128'(busy), 128'(1'b1));
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) break;
    end
    check_value("lat256", 128'(cyc), 128'(53));
    read_rk(4'd14, d, o, d2, o2);
    check_value("rk256_14_c3", 128'(get_col(d, 3)), 128'(32'h706c631e));
    read_rk(4'd15, d, o, d2, o2);
    check_value("rk256_15_oob", 128'(o), 128'(1'b1));

    // Asynchronous reset in the middle of an expansion.
    @(negedge clk);
    key_in = k128; key_len = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_value("mrst_busy", 128'(busy), 128'(1'b0));
    check_value("mrst_done", 128'(done), 128'(1'b0));
    check_value("mrst_keys_ready", 128'(keys_ready), 128'(1'b0));
    check_value("mrst_rk_oob", 128'(rk_oob), 128'(1'b1));
    check_value("mrst_rk_data", rk_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_key(k128, 2'b00, 1'b0, cyc);
    check_value("lat128_again", 128'(cyc), 128'(41));
    read_rk(4'd10, d, o, d2, o2);
    check_value("rk128_10_again", d, make_rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));

`ifdef KS_ZEROIZE_EN
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check_value("zero_keys_ready", 128'(keys_ready), 128'(1'b0));
    @(negedge clk);
    check_value("zero_rk_oob", 128'(rk_oob), 128'(1'b1));
    check_value("zero_rk_data", rk_data, 128'h0);
    @(negedge clk);
    key_in = k128; key_len = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    begin
      int ndone;
      ndone = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      check_value("zero_mid_no_done", 128'(ndone), 128'(0));
    end
    check_value("zero_mid_idle", 128'(busy), 128'(1'b0));
    run_key(k128, 2'b00, 1'b0, cyc);
    check_value("lat128_zero", 128'(cyc), 128'(41));
    read_rk(4'd10, d, o, d2, o2);
    check_value("rk128_10_zero", d, make_rk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
